res_tx_fmt: RTL and testbench
=============================

# res_tx_fmt

Result formatter/transmitter for the calculator datapath: the outbound counterpart of the command interpreter. Captures the ALU result on a `rdy` pulse, converts it to decimal ASCII, and feeds the characters one at a time to the UART transmitter over a strobe/busy handshake, terminated by CR LF. It sits between the ALU output and the UART TX, mirroring how the interpreter sits between the UART RX and the ALU.

## Interface
- `W`, default 16: result width in bits; at most 5 decimal digits are emitted.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `result`  in  W  ALU result; sampled only on `rdy`.
- `err`  in  1  ALU error, e.g. divide by zero; sampled with `rdy`.
- `rdy`  in  1  one-cycle request to format and send `result`.
- `tx_busy`  in  1  UART TX busy; high while a character is shifting out.
- `tx_data`  out  8  ASCII character to the UART TX; valid while `tx_strt` is high.
- `tx_strt`  out  1  one-cycle strobe that launches `tx_data`.
- `busy`  out  1  high from `rdy` acceptance until the LF handshake completes.
- `ovr`  out  1  one-cycle pulse when a `rdy` is dropped because `busy` is high.

## Operation
- Reset values: `tx_data`=8'h00, `tx_strt`=0, `busy`=0, `ovr`=0, FSM in IDLE, captured registers cleared.
- States are IDLE, CONV, SIGN, DIGIT, CR, LF, WAIT_HI and WAIT_LO.
- **IDLE**
  - On `rdy`: latch `result` and `err`, then set `busy`.
  - If `err`=1: go to DIGIT with a single character 'E' (8'h45) and no conversion.
  - Otherwise: go to CONV.
- **CONV**
  - Magnitude = |`result`|, or `result` unchanged when unsigned (see Configuration).
  - Sequential double-dabble runs for exactly W cycles and produces five BCD digits.
- **SIGN**
  - Entered only when signed and negative; emits '-' (8'h2D).
- **DIGIT**
  - Emits digits most significant first as 8'h30+digit.
  - Leading zeros are suppressed; the ones digit is always emitted, so 0 gives "0".
- **CR, LF**: emit 8'h0D, then 8'h0A. After the LF handshake, return to IDLE and clear `busy`.
- **Per-character handshake**
  - In an emit state with `tx_busy`=0: drive `tx_data` and pulse `tx_strt` for one cycle, then go to WAIT_HI.
  - WAIT_HI waits for `tx_busy`=1; WAIT_LO waits for `tx_busy`=0; then advance to the next emit state.
  - `tx_data` holds its value until the next strobe.
- `rdy` while `busy`=1: ignored. `ovr` pulses on the next cycle; the transmission in progress is unaffected.
- `rdy` in the same cycle `busy` falls: ignored and flagged via `ovr`. The request is accepted only when `busy` was already 0.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). A character already handed to the UART is not recalled.
- `result`/`err` changing after capture has no effect.

## Timing
- `rdy` is sampled at edge N; `busy` is high from after edge N.
- CONV occupies edges N+1..N+W.
- The first `tx_strt` is high in the cycle after edge N+W+1, provided `tx_busy`=0; this is 17 cycles after `rdy` for W=16.
- On the error path, 'E' strobes in the cycle after edge N+1.
- Each `tx_strt` is exactly one cycle wide.
- There is at least one idle cycle between consecutive strobes, plus UART time.
- `ovr` is registered, one cycle after the offending `rdy`.

## Configuration
- `RES_SIGNED_EN` defined:
  - `result` is two's complement and the SIGN state is compiled in.
  - The magnitude of the most negative value, 2^(W-1), converts correctly.
- Not defined:
  - `result` is unsigned and SIGN is removed.
  - The MSB is treated as magnitude and '-' is never emitted.

## Structure
- Shared package `calc_pkg`:
  - ASCII constants for '0', '-', 'E', CR, LF.
  - The `res_tx_fmt` state encoding.
  - The digit-count constant 5.
  - The same ASCII constants the interpreter decodes; both blocks are to use the package.
- Sub-module `bin2bcd_seq`:
  - W-bit to 5-digit sequential double-dabble.
  - Ports: `start`, `bin`, `bcd[19:0]`, `done`.
  - `done` pulses W cycles after `start`.

## Test plan
- `result`=42, `err`=0, UART model busy for 10 cycles per character -> `tx_data` sequence 34,32,0D,0A; `busy` falls after the LF handshake.
- `result`=0 -> 30,0D,0A. `result`=32767 -> 33,32,37,36,37,0D,0A.
- `RES_SIGNED_EN`, `result`=16'hFFF9 (-7) -> 2D,37,0D,0A; `result`=16'h8000 -> 2D,33,32,37,36,38,0D,0A. Without the macro, 16'hFFF9 -> 36,35,35,32,39,0D,0A.
- `err`=1 with any `result` -> 45,0D,0A with no CONV cycles; first strobe one cycle after acceptance.
- Second `rdy` during transmission of 42 -> `ovr` pulses once, output stays 34,32,0D,0A, no extra characters.
- `rst_n` low while WAIT_LO of the second digit -> `tx_strt`, `busy` and `ovr` are 0 immediately. After release, a new `rdy` with 5 -> 35,0D,0A.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: ASCII character codes
// used by both the command interpreter and the result formatter, the
// result formatter's state encoding, BCD sizing and a digit helper.
package calc_pkg;

    // Character codes shared by the interpreter (decode) and formatter (encode)
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Decimal output is at most five digits (enough for a 16-bit magnitude)
    localparam int N_DIGITS = 5;
    localparam int BCD_W    = 4 * N_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIGN,
        ST_DIGIT,
        ST_CR,
        ST_LF,
        ST_WAIT_HI,
        ST_WAIT_LO
    } res_tx_state_e;

    // Index of the most significant non-zero BCD digit; 0 when all digits
    // are zero so that the ones digit is always printed.
    function automatic logic [2:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: W-bit binary to five BCD digits.
// The first shift step is applied in the same edge that loads the operand,
// so the remaining W-1 steps follow and done pulses W cycles after start.
module bin2bcd_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic [19:0]      bcd,
    output logic             done
);
    import calc_pkg::*;

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [BCD_W-1:0] src_bcd;
    logic [BCD_W-1:0] adj_bcd;
    logic [W-1:0]     src_bin;

    assign src_bcd = start ? '0 : bcd_q;
    assign src_bin = start ? bin : bin_q;

    // Add-3 correction on every digit that would overflow when doubled
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
        assign adj_bcd[4*gi +: 4] = (src_bcd[4*gi +: 4] >= 4'd5) ?
                                    src_bcd[4*gi +: 4] + 4'd3 :
                                    src_bcd[4*gi +: 4];
    end

    // One shift step per cycle while a conversion is in flight
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            bcd_d  = {adj_bcd[BCD_W-2:0], src_bin[W-1]};
            bin_d  = src_bin << 1;
            cnt_d  = CW'(W - 1);
            done_d = (W == 1);
        end else if (cnt_q != '0) begin
            bcd_d  = {adj_bcd[BCD_W-2:0], src_bin[W-1]};
            bin_d  = src_bin << 1;
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    // Conversion state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/res_tx_fmt.sv
// Result formatter/transmitter: captures an ALU result on rdy, converts it
// to decimal ASCII and hands characters to the UART TX one at a time over
// a strobe/busy handshake, terminated by CR LF. Errors print a single 'E'.
// Build option: define RES_SIGNED_EN to treat result as two's complement
// and prefix negative values with '-'; otherwise result is unsigned.
module res_tx_fmt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] result,
    input  logic         err,
    input  logic         rdy,
    input  logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         tx_strt,
    output logic         busy,
    output logic         ovr
);
    import calc_pkg::*;

    res_tx_state_e state_q, state_d;
    res_tx_state_e nxt_q, nxt_d;
    logic          err_q, err_d;
    logic [2:0]    dig_idx_q, dig_idx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_strt_q, tx_strt_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;

    logic [W-1:0]     mag;
    logic             start_conv;
    logic [BCD_W-1:0] bcd;
    logic             bcd_done;
    logic [3:0]       cur_dig;

    logic          emit;
    logic [7:0]    emit_char;
    res_tx_state_e emit_next;

`ifdef RES_SIGNED_EN
    logic neg_q, neg_d;
    // Two's complement magnitude; 2^(W-1) maps onto itself, read as unsigned
    assign mag = result[W-1] ? (~result + 1'b1) : result;
`else
    assign mag = result;
`endif

    assign start_conv = rdy && !busy_q && !err;
    assign cur_dig    = bcd[{dig_idx_q, 2'b00} +: 4];

    bin2bcd_seq #(.W(W)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_conv),
        .bin   (mag),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    // Next-state and output decode; emit states share one handshake path
    always_comb begin
        state_d   = state_q;
        nxt_d     = nxt_q;
        err_d     = err_q;
        dig_idx_d = dig_idx_q;
        tx_data_d = tx_data_q;
        tx_strt_d = 1'b0;
        busy_d    = busy_q;
        ovr_d     = rdy && busy_q;
        emit      = 1'b0;
        emit_char = tx_data_q;
        emit_next = ST_IDLE;
`ifdef RES_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rdy && !busy_q) begin
                    busy_d    = 1'b1;
                    err_d     = err;
                    dig_idx_d = 3'd0;
`ifdef RES_SIGNED_EN
                    neg_d     = result[W-1] && !err;
`endif
                    state_d   = err ? ST_DIGIT : ST_CONV;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    dig_idx_d = msd_index(bcd);
`ifdef RES_SIGNED_EN
                    state_d   = neg_q ? ST_SIGN : ST_DIGIT;
`else
                    state_d   = ST_DIGIT;
`endif
                end
            end
`ifdef RES_SIGNED_EN
            ST_SIGN: begin
                emit      = 1'b1;
                emit_char = ASCII_MINUS;
                emit_next = ST_DIGIT;
            end
`endif
            ST_DIGIT: begin
                emit = 1'b1;
                if (err_q) begin
                    emit_char = ASCII_E;
                    emit_next = ST_CR;
                end else begin
                    emit_char = ASCII_0 + {4'd0, cur_dig};
                    emit_next = (dig_idx_q == 3'd0) ? ST_CR : ST_DIGIT;
                end
            end
            ST_CR: begin
                emit      = 1'b1;
                emit_char = ASCII_CR;
                emit_next = ST_LF;
            end
            ST_LF: begin
                emit      = 1'b1;
                emit_char = ASCII_LF;
                emit_next = ST_IDLE;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = nxt_q;
                    if (nxt_q == ST_IDLE) begin
                        busy_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit && !tx_busy) begin
            tx_data_d = emit_char;
            tx_strt_d = 1'b1;
            nxt_d     = emit_next;
            state_d   = ST_WAIT_HI;
            if (state_q == ST_DIGIT && !err_q && dig_idx_q != 3'd0) begin
                dig_idx_d = dig_idx_q - 3'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            nxt_q     <= ST_IDLE;
            err_q     <= 1'b0;
            dig_idx_q <= 3'd0;
            tx_data_q <= 8'h00;
            tx_strt_q <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef RES_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nxt_q     <= nxt_d;
            err_q     <= err_d;
            dig_idx_q <= dig_idx_d;
            tx_data_q <= tx_data_d;
            tx_strt_q <= tx_strt_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
`ifdef RES_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign tx_data = tx_data_q;
    assign tx_strt = tx_strt_q;
    assign busy    = busy_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_res_tx_fmt.sv
// Self-checking bench for res_tx_fmt: expected characters are queued when a
// request is driven and compared as the DUT strobes them into a UART model.
module tb_res_tx_fmt;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] result = '0;
    logic         err = 1'b0;
    logic         rdy = 1'b0;
    logic         tx_busy = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_strt;
    logic         busy;
    logic         ovr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int strobes = 0;
    int ovr_cnt = 0;
    int acc_cyc = 0;
    int exp_lat = -1;
    logic [7:0] exp_q[$];

    res_tx_fmt #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .result  (result),
        .err     (err),
        .rdy     (rdy),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_strt (tx_strt),
        .busy    (busy),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ovr) ovr_cnt <= ovr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference formatting: decimal text of the value, or 'E', then CR LF
    task automatic push_exp(input logic [W-1:0] r, input logic e);
        string s;
        if (e) begin
            exp_q.push_back(8'h45);
        end else begin
`ifdef RES_SIGNED_EN
            s = $sformatf("%0d", $signed(r));
`else
            s = $sformatf("%0d", r);
`endif
            for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // UART model: accept a strobe, compare, then stay busy for 10 cycles
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_strt) begin
                strobes++;
                if (exp_lat >= 0) begin
                    check("first_strobe_latency", cyc - acc_cyc, exp_lat);
                    exp_lat = -1;
                end
                check("char_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e);
                    if (e == 8'h0A) check("busy_at_lf", busy, 1);
                end
                @(negedge clk);
                check("strobe_width", tx_strt, 0);
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] r, input logic e);
        @(negedge clk);
        result = r;
        err    = e;
        rdy    = 1'b1;
        push_exp(r, e);
        @(negedge clk);
        rdy     = 1'b0;
        acc_cyc = cyc;
        exp_lat = e ? 1 : W + 1;
        check("busy_rise", busy, 1);
        check("no_ovr_on_accept", ovr, 0);
        // Inputs changing after capture must not matter
        result = W'($urandom);
        err    = 1'($urandom);
        $display("txn result=%04h err=%0b", r, e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", n < 3000, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int s0;
        int n;
        int o0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_strt", tx_strt, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(16'd42, 1'b0);     wait_idle();
        send(16'd0, 1'b0);      wait_idle();
        send(16'd32767, 1'b0);  wait_idle();
        send(16'hFFF9, 1'b0);   wait_idle();
        send(16'h8000, 1'b0);   wait_idle();
        send(16'd65535, 1'b0);  wait_idle();
        send(16'd1234, 1'b1);   wait_idle();

        // Overrun: second request during transmission is dropped and flagged
        o0 = ovr_cnt;
        send(16'd42, 1'b0);
        repeat (30) @(negedge clk);
        rdy    = 1'b1;
        result = 16'd99;
        @(negedge clk);
        rdy = 1'b0;
        check("ovr_pulse", ovr, 1);
        @(negedge clk);
        check("ovr_width", ovr, 0);
        wait_idle();
        check("ovr_count", ovr_cnt - o0, 1);

        // Asynchronous reset while waiting for the second digit to finish
        s0 = strobes;
        send(16'd42, 1'b0);
        n = 0;
        while (strobes < s0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("second_digit_seen", strobes - s0, 2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_strt", tx_strt, 0);
        check("arst_busy", busy, 0);
        check("arst_ovr", ovr, 0);
        check("arst_tx_data", tx_data, 8'h00);
        exp_q.delete();
        exp_lat = -1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        send(16'd5, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
